// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes MIPS ALU instructions and queues operands for the execute stage
module alu_issue_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    output logic [4:0]       dest_reg,
    output logic             dest_we,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_NOR  = 4'd11;
    localparam logic [3:0] ALU_XXX  = 4'd15;
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  dst;
        logic        we;
        logic        ill;
    } entry_t;

    entry_t           dec;
    entry_t           head;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] ic_q, ic_d;
    logic             acc, pop;

    logic [5:0]  opc, fn;
    logic [4:0]  rd, rt, sh;
    logic [31:0] imm_s, imm_z;

    assign opc   = instr[31:26];
    assign fn    = instr[5:0];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign sh    = instr[10:6];
    assign imm_s = {{16{instr[15]}}, instr[15:0]};
    assign imm_z = {16'b0, instr[15:0]};

    // Decode the incoming instruction into operand placement, ALU op and destination
    always_comb begin
        dec     = '0;
        dec.op  = ALU_XXX;
        dec.ill = 1'b1;
        if (opc == 6'h00) begin
            dec.dst = rd;
            dec.ill = 1'b0;
            case (fn)
                6'h21: begin dec.op = ALU_ADDU; dec.a = rs_data; dec.b = rt_data; end
                6'h23: begin dec.op = ALU_SUBU; dec.a = rs_data; dec.b = rt_data; end
                6'h24: begin dec.op = ALU_AND;  dec.a = rs_data; dec.b = rt_data; end
                6'h25: begin dec.op = ALU_OR;   dec.a = rs_data; dec.b = rt_data; end
                6'h26: begin dec.op = ALU_XOR;  dec.a = rs_data; dec.b = rt_data; end
                6'h27: begin dec.op = ALU_NOR;  dec.a = rs_data; dec.b = rt_data; end
                6'h2A: begin dec.op = ALU_SLT;  dec.a = rs_data; dec.b = rt_data; end
                6'h2B: begin dec.op = ALU_SLTU; dec.a = rs_data; dec.b = rt_data; end
                6'h00: begin dec.op = ALU_SLL;  dec.a = rt_data; dec.b = {27'b0, sh}; end
                6'h02: begin dec.op = ALU_SRL;  dec.a = rt_data; dec.b = {27'b0, sh}; end
                6'h03: begin dec.op = ALU_SRA;  dec.a = {27'b0, sh}; dec.b = rt_data; end
                6'h04: begin dec.op = ALU_SLL;  dec.a = rt_data; dec.b = {27'b0, rs_data[4:0]}; end
                6'h06: begin dec.op = ALU_SRL;  dec.a = rt_data; dec.b = {27'b0, rs_data[4:0]}; end
                6'h07: begin dec.op = ALU_SRA;  dec.a = {27'b0, rs_data[4:0]}; dec.b = rt_data; end
                default: dec.ill = 1'b1;
            endcase
        end else begin
            dec.dst = rt;
            dec.ill = 1'b0;
            case (opc)
                6'h09: begin dec.op = ALU_ADDU; dec.a = rs_data; dec.b = imm_s; end
                6'h0A: begin dec.op = ALU_SLT;  dec.a = rs_data; dec.b = imm_s; end
                6'h0B: begin dec.op = ALU_SLTU; dec.a = rs_data; dec.b = imm_s; end
                6'h0C: begin dec.op = ALU_AND;  dec.a = rs_data; dec.b = imm_z; end
                6'h0D: begin dec.op = ALU_OR;   dec.a = rs_data; dec.b = imm_z; end
                6'h0E: begin dec.op = ALU_XOR;  dec.a = rs_data; dec.b = imm_z; end
                6'h0F: begin dec.op = ALU_LUI;  dec.a = imm_z;   dec.b = 32'b0; end
                default: dec.ill = 1'b1;
            endcase
        end
        if (dec.ill) begin
            dec.op  = ALU_XXX;
            dec.a   = '0;
            dec.b   = '0;
            dec.dst = '0;
        end
        dec.we = ~dec.ill & (dec.dst != 5'd0);
    end

    assign out_valid = cnt_q != '0;
    assign in_ready  = in_ready_q;
    assign acc       = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign head      = mem_q[rp_q];

    // Queue pointers, occupancy, storage write and saturating illegal counter
    always_comb begin
        mem_d = mem_q;
        if (acc) mem_d[wp_q] = dec;
        wp_d       = wp_q + PW'(acc);
        rp_d       = rp_q + PW'(pop);
        cnt_d      = cnt_q + (PW+1)'(acc) - (PW+1)'(pop);
        in_ready_d = cnt_d < (PW+1)'(DEPTH);
        ic_d       = (acc & dec.ill & ~&ic_q) ? ic_q + 1'b1 : ic_q;
    end

    // State registers; reset empties the queue and holds off input until released
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            ic_q       <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            ic_q       <= ic_d;
        end
    end

    // Head fields are masked when empty so no stale entry is ever visible
    always_comb begin
        alu_a       = out_valid ? head.a : '0;
        alu_b       = out_valid ? head.b : '0;
        alu_op      = out_valid ? head.op : ALU_XXX;
        dest_reg    = out_valid ? head.dst : '0;
        dest_we     = out_valid & head.we;
        illegal     = out_valid & head.ill;
        illegal_cnt = ic_q;
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: random and directed checking of alu_issue_stage against a queue model
module tb_alu_issue_stage;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;
    localparam logic [3:0] ADDU = 0, SUBU = 1, SLT = 2, SLTU = 3, AND_ = 4, OR_ = 5, XOR_ = 6,
                           LUI = 7, SLL = 8, SRL = 9, SRA = 10, NOR_ = 11, XXX = 15;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  d;
        logic        we;
        logic        ill;
    } ent_t;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [31:0] instr = 0, rs_data = 0, rt_data = 0;
    logic in_ready, out_valid, dest_we, illegal;
    logic [31:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic [4:0] dest_reg;
    logic [CNT_W-1:0] illegal_cnt;

    int n_cmp = 0, n_bad = 0;
    ent_t q[$];
    int m_cnt = 0;
    bit m_rdy = 0;

    alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .dest_reg(dest_reg),
        .dest_we(dest_we), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    function automatic ent_t mdec(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        ent_t e;
        logic [31:0] sh, rv, se, ze;
        sh = 32'(i[10:6]);
        rv = 32'(rs[4:0]);
        se = 32'(signed'(i[15:0]));
        ze = 32'(i[15:0]);
        e = '{a: 0, b: 0, op: XXX, d: 0, we: 0, ill: 0};
        if (i[31:26] == 0) begin
            e.d = i[15:11];
            case (i[5:0])
                6'h21: e = '{rs, rt, ADDU, e.d, 0, 0};
                6'h23: e = '{rs, rt, SUBU, e.d, 0, 0};
                6'h24: e = '{rs, rt, AND_, e.d, 0, 0};
                6'h25: e = '{rs, rt, OR_, e.d, 0, 0};
                6'h26: e = '{rs, rt, XOR_, e.d, 0, 0};
                6'h27: e = '{rs, rt, NOR_, e.d, 0, 0};
                6'h2A: e = '{rs, rt, SLT, e.d, 0, 0};
                6'h2B: e = '{rs, rt, SLTU, e.d, 0, 0};
                6'h00: e = '{rt, sh, SLL, e.d, 0, 0};
                6'h02: e = '{rt, sh, SRL, e.d, 0, 0};
                6'h03: e = '{sh, rt, SRA, e.d, 0, 0};
                6'h04: e = '{rt, rv, SLL, e.d, 0, 0};
                6'h06: e = '{rt, rv, SRL, e.d, 0, 0};
                6'h07: e = '{rv, rt, SRA, e.d, 0, 0};
                default: e.ill = 1;
            endcase
        end else begin
            e.d = i[20:16];
            case (i[31:26])
                6'h09: e = '{rs, se, ADDU, e.d, 0, 0};
                6'h0A: e = '{rs, se, SLT, e.d, 0, 0};
                6'h0B: e = '{rs, se, SLTU, e.d, 0, 0};
                6'h0C: e = '{rs, ze, AND_, e.d, 0, 0};
                6'h0D: e = '{rs, ze, OR_, e.d, 0, 0};
                6'h0E: e = '{rs, ze, XOR_, e.d, 0, 0};
                6'h0F: e = '{ze, 0, LUI, e.d, 0, 0};
                default: e.ill = 1;
            endcase
        end
        if (e.ill) e = '{a: 0, b: 0, op: XXX, d: 0, we: 0, ill: 1};
        e.we = !e.ill && e.d != 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction step per rising edge, from the inputs as driven
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt = 0;
            m_rdy = 0;
        end else begin
            bit acc, pop;
            ent_t e;
            e = mdec(instr, rs_data, rt_data);
            acc = in_valid && m_rdy;
            pop = out_ready && q.size() > 0;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (acc && e.ill && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_rdy = q.size() < DEPTH;
        end
    end

    // Compare every DUT output with the model on each falling edge
    always @(negedge clk) begin
        ent_t h;
        h = q.size() > 0 ? q[0] : '{a: 0, b: 0, op: XXX, d: 0, we: 0, ill: 0};
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
        chk("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
        chk("alu_a", 64'(alu_a), 64'(h.a));
        chk("alu_b", 64'(alu_b), 64'(h.b));
        chk("alu_op", 64'(alu_op), 64'(h.op));
        chk("dest_reg", 64'(dest_reg), 64'(h.d));
        chk("dest_we", 64'(dest_we), 64'(h.we));
        chk("illegal", 64'(illegal), 64'(h.ill));
    end

    task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ordy, input logic r);
        in_valid = v; instr = i; rs_data = rs; rt_data = rt; out_ready = ordy; rst = r;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [5:0] rf[14] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        logic [5:0] io[7] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4) return {6'h00, w[25:6], rf[$urandom_range(0, 13)]};
        if (k < 7) return {io[$urandom_range(0, 6)], w[25:0]};
        if (k == 7) return {6'h00, w[25:16], 5'd0, w[10:6], rf[$urandom_range(0, 13)]};
        return w;
    endfunction

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_op", 64'(alu_op), 64'(XXX));
        cyc(0, 0, 0, 0, 0, 0);
        chk("post_rst_in_ready", 64'(in_ready), 1);
        cyc(1, 32'h00430821, 5, 7, 0, 0);
        chk("addu_valid", 64'(out_valid), 1);
        chk("addu_a", 64'(alu_a), 5);
        chk("addu_b", 64'(alu_b), 7);
        chk("addu_op", 64'(alu_op), 64'(ADDU));
        chk("addu_dst", 64'({dest_reg, dest_we}), 64'({5'd1, 1'b1}));
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 32'h000520C3, 32'h1F, 32'h80000000, 0, 0);
        chk("sra_a", 64'(alu_a), 3);
        chk("sra_b", 64'(alu_b), 64'h80000000);
        chk("sra_op_dst", 64'({alu_op, dest_reg}), 64'({SRA, 5'd4}));
        cyc(1, 32'h2528FFFF, 1, 2, 1, 0);
        chk("addiu_b", 64'(alu_b), 64'hFFFFFFFF);
        chk("addiu_dst", 64'(dest_reg), 8);
        cyc(1, 32'h3528FFFF, 1, 2, 1, 0);
        chk("ori_b", 64'(alu_b), 64'h0000FFFF);
        cyc(1, 32'h3C011234, 9, 9, 1, 0);
        chk("lui_ab", 64'({alu_a, alu_b}), 64'h00001234_00000000);
        cyc(1, 32'hFC000000, 9, 9, 1, 0);
        chk("ill_flags", 64'({illegal, dest_we, alu_op}), 64'({1'b1, 1'b0, XXX}));
        chk("ill_cnt", 64'(illegal_cnt), 1);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc(1, 32'hFC000000, 0, 0, 1, 0);
        chk("ill_sat", 64'(illegal_cnt), 64'((1 << CNT_W) - 1));
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 32'h00430821, 1, 1, 0, 0);
        cyc(1, 32'h00430821, 2, 2, 0, 0);
        cyc(1, 32'h00430821, 3, 3, 0, 0);
        chk("bp_in_ready", 64'(in_ready), 0);
        chk("bp_head", 64'(alu_a), 1);
        cyc(1, 32'h00430821, 3, 3, 0, 0);
        chk("bp_head_stable", 64'(alu_a), 1);
        cyc(1, 32'h00430821, 3, 3, 1, 0);
        chk("bp_second", 64'(alu_a), 2);
        chk("bp_ready_after_pop", 64'(in_ready), 1);
        cyc(1, 32'h00430821, 3, 3, 1, 0);
        chk("bp_third", 64'(alu_a), 3);
        cyc(1, 32'h00430821, 4, 4, 0, 0);
        cyc(1, 32'hFC000000, 5, 5, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst_flush_valid", 64'(out_valid), 0);
        chk("rst_flush_cnt", 64'(illegal_cnt), 0);
        chk("rst_flush_a", 64'(alu_a), 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
